// File: rtl/phase_diff_avg_pkg.sv
// Shared types, default widths and wrap-safe phase helpers for phase_diff_averager.
package phase_diff_avg_pkg;

  typedef enum logic {S_FIRST, S_ACC} state_t;

  localparam int PH_WIDTH_DEF   = 32;
  localparam int AVG_LOG2_DEF   = 4;
  localparam int MAX_FRAMES_DEF = 64;
  localparam int SUM_WIDTH      = PH_WIDTH_DEF + AVG_LOG2_DEF;
  localparam int CNT_WIDTH      = $clog2(MAX_FRAMES_DEF + 1);
  localparam int WRAP_MAX       = 64;

  function automatic int sum_width(input int ph_w, input int avg_log2);
    return ph_w + avg_log2;
  endfunction

  function automatic int cnt_width(input int max_frames);
    return $clog2(max_frames + 1);
  endfunction

  // Difference a-b taken modulo 2^ph_w, returned sign-extended to WRAP_MAX bits.
  function automatic logic signed [WRAP_MAX-1:0] wrap_sub(input logic [WRAP_MAX-1:0] a,
                                                         input logic [WRAP_MAX-1:0] b,
                                                         input int                  ph_w);
    logic [WRAP_MAX-1:0] diff;
    diff = (a - b) << (WRAP_MAX - ph_w);
    return $signed(diff) >>> (WRAP_MAX - ph_w);
  endfunction

endpackage

// File: rtl/phase_diff_averager.sv
// Magnitude-gated, wrap-safe block averager of phase differences; one result
// (or timeout error) per block of accepted frames.
module phase_diff_averager
  import phase_diff_avg_pkg::*;
#(
  parameter int PH_WIDTH   = 32,
  parameter int MAG_WIDTH  = 32,
  parameter int AVG_LOG2   = 4,
  parameter int MAX_FRAMES = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_vld,
  input  logic [PH_WIDTH-1:0]                 delta_ph,
  input  logic [MAG_WIDTH-1:0]                mag,
  input  logic [MAG_WIDTH-1:0]                mag_thr,
  input  logic                                clr,
  output logic                                o_vld,
  output logic [PH_WIDTH-1:0]                 ph_avg,
  output logic                                o_err,
  output logic [$clog2(MAX_FRAMES+1)-1:0]     n_rej
);

  localparam int SUM_W = sum_width(PH_WIDTH, AVG_LOG2);
  localparam int CNT_W = cnt_width(MAX_FRAMES);
  localparam int ACC_W = AVG_LOG2 + 1;
  localparam logic [ACC_W-1:0]        ACC_LAST = ACC_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0]        FRM_LAST = CNT_W'(MAX_FRAMES - 1);
  localparam logic signed [SUM_W-1:0] HALF     = SUM_W'(longint'(1) << (AVG_LOG2 - 1));

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [PH_WIDTH-1:0]       r_ref;
  logic signed [SUM_W-1:0]   r_sum;
  logic [ACC_W-1:0]          r_acc_cnt;
  logic [CNT_W-1:0]          r_frm_cnt;
  logic [CNT_W-1:0]          r_rej_cnt;

  logic                      r_o_vld;
  logic [PH_WIDTH-1:0]       r_ph_avg;
  logic                      r_o_err;
  logic [CNT_W-1:0]          r_n_rej;

  logic                      w_accept;
  logic                      w_reject;
  logic                      w_complete;
  logic                      w_timeout;
  logic [CNT_W-1:0]          w_rej_nxt;
  logic signed [SUM_W-1:0]   w_d;
  logic signed [SUM_W-1:0]   w_sum_nxt;
  logic signed [SUM_W-1:0]   w_rnd;
  logic [PH_WIDTH-1:0]       w_avg;

  always_comb begin
    // NOTE: every variable gets a default first so no path can leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_accept    = i_vld && (mag >= mag_thr);
    w_reject    = i_vld && !w_accept;
    w_rej_nxt   = r_rej_cnt + CNT_W'(w_reject);
    w_d         = SUM_W'(wrap_sub(64'(delta_ph), 64'(r_ref), PH_WIDTH));
    w_sum_nxt   = r_sum + w_d;
    // Round half up: add half an LSB of the result, then arithmetic shift.
    w_rnd       = (w_sum_nxt + HALF) >>> AVG_LOG2;
    w_avg       = r_ref + PH_WIDTH'(w_rnd);
    w_complete  = w_accept && (r_state == S_ACC) && (r_acc_cnt == ACC_LAST);
    w_timeout   = i_vld && (r_frm_cnt == FRM_LAST) && !w_complete;

    if (clr || w_complete || w_timeout) begin
      w_state_nxt = S_FIRST;
    end else if (w_accept && (r_state == S_FIRST)) begin
      w_state_nxt = S_ACC;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FIRST;
      r_ref     <= '0;
      r_sum     <= '0;
      r_acc_cnt <= '0;
      r_frm_cnt <= '0;
      r_rej_cnt <= '0;
      r_o_vld   <= 1'b0;
      r_ph_avg  <= '0;
      r_o_err   <= 1'b0;
      r_n_rej   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_o_vld <= 1'b0;
      if (clr || w_complete || w_timeout) begin
        // The ending frame and a clr both start a fresh block on this edge.
        r_ref     <= '0;
        r_sum     <= '0;
        r_acc_cnt <= '0;
        r_frm_cnt <= '0;
        r_rej_cnt <= '0;
        if (!clr) begin
          r_o_vld  <= 1'b1;
          r_o_err  <= w_timeout;
          r_ph_avg <= w_complete ? w_avg : '0;
          r_n_rej  <= w_rej_nxt;
        end
      end else if (i_vld) begin
        r_frm_cnt <= r_frm_cnt + 1'b1;
        r_rej_cnt <= w_rej_nxt;
        if (w_accept) begin
          r_acc_cnt <= r_acc_cnt + 1'b1;
          if (r_state == S_FIRST) begin
            r_ref <= delta_ph;
            r_sum <= '0;
          end else begin
            r_sum <= w_sum_nxt;
          end
        end
      end
    end
  end

  assign o_vld  = r_o_vld;
  assign ph_avg = r_ph_avg;
  assign o_err  = r_o_err;
  assign n_rej  = r_n_rej;

endmodule

// File: tb/tb_phase_diff_averager.sv
// Scoreboard bench for phase_diff_averager (AVG_LOG2=2, MAX_FRAMES=8): directed cases plus random frames.
module tb_phase_diff_averager;

  localparam int PH_W   = 32;
  localparam int MAG_W  = 32;
  localparam int AVG_L2 = 2;
  localparam int MAXF   = 8;
  localparam int N_ACC  = 1 << AVG_L2;
  localparam int CNT_W  = $clog2(MAXF + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              i_vld;
  logic [PH_W-1:0]   delta_ph;
  logic [MAG_W-1:0]  mag;
  logic [MAG_W-1:0]  mag_thr;
  logic              clr;
  logic              o_vld;
  logic [PH_W-1:0]   ph_avg;
  logic              o_err;
  logic [CNT_W-1:0]  n_rej;

  phase_diff_averager #(
    .PH_WIDTH  (PH_W),
    .MAG_WIDTH (MAG_W),
    .AVG_LOG2  (AVG_L2),
    .MAX_FRAMES(MAXF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_vld    (i_vld),
    .delta_ph (delta_ph),
    .mag      (mag),
    .mag_thr  (mag_thr),
    .clr      (clr),
    .o_vld    (o_vld),
    .ph_avg   (ph_avg),
    .o_err    (o_err),
    .n_rej    (n_rej)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [PH_W-1:0]  ph;
    logic             err;
    logic [CNT_W-1:0] nrej;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model state: the accepted phases of the current block and its counters.
  logic [PH_W-1:0] m_acc[$];
  int              m_rej = 0;
  int              m_frm = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [PH_W-1:0] model_avg();
    logic [PH_W-1:0] r;
    longint          s;
    longint          q;
    longint          f;
    r = m_acc[0];
    s = 0;
    foreach (m_acc[i]) s += longint'(int'(m_acc[i] - r));
    q = s + N_ACC / 2;
    f = (q >= 0) ? q / N_ACC : -((-q + N_ACC - 1) / N_ACC);
    return r + PH_W'(f);
  endfunction

  task automatic model_clear();
    m_acc.delete();
    m_rej = 0;
    m_frm = 0;
  endtask

  task automatic model_frame(input logic [PH_W-1:0] ph, input logic [MAG_W-1:0] m,
                             input logic [MAG_W-1:0] t);
    exp_t e;
    m_frm++;
    if (m >= t) m_acc.push_back(ph);
    else        m_rej++;
    if (m_acc.size() == N_ACC) begin
      e.ph = model_avg(); e.err = 1'b0; e.nrej = CNT_W'(m_rej); e.cyc = cyc + 1;
      sb.push_back(e);
      model_clear();
    end else if (m_frm == MAXF) begin
      e.ph = '0; e.err = 1'b1; e.nrej = CNT_W'(m_rej); e.cyc = cyc + 1;
      sb.push_back(e);
      model_clear();
    end
  endtask

  task automatic send(input logic [PH_W-1:0] ph, input logic [MAG_W-1:0] m,
                      input logic [MAG_W-1:0] t);
    @(negedge clk);
    i_vld = 1'b1; clr = 1'b0; delta_ph = ph; mag = m; mag_thr = t;
    model_frame(ph, m, t);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_vld = 1'b0; clr = 1'b0;
    end
  endtask

  task automatic do_clr(input logic with_vld);
    @(negedge clk);
    clr = 1'b1; i_vld = with_vld; delta_ph = $urandom; mag = 32'd5000; mag_thr = '0;
    model_clear();
  endtask

  task automatic check_out(input string tag, input logic [PH_W-1:0] ph, input logic err,
                           input logic [CNT_W-1:0] nr);
    check({tag, "_ph"},   64'(ph_avg), 64'(ph));
    check({tag, "_err"},  64'(o_err),  64'(err));
    check({tag, "_nrej"}, 64'(n_rej),  64'(nr));
  endtask

  // Monitor: every o_vld pops one expectation; an overdue expectation is a missing o_vld.
  always @(negedge clk) begin
    exp_t e;
    if (o_vld === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_vld", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("vld_cycle", 64'(cyc), 64'(e.cyc));
        check("sb_ph",     64'(ph_avg), 64'(e.ph));
        check("sb_err",    64'(o_err),  64'(e.err));
        check("sb_nrej",   64'(n_rej),  64'(e.nrej));
      end
    end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
      check("missing_vld", 64'd0, 64'd1);
      void'(sb.pop_front());
    end
  end

  initial begin
    rst = 1'b1; i_vld = 1'b0; clr = 1'b0; delta_ph = '0; mag = '0; mag_thr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_vld", 64'(o_vld), 64'd0);
    check_out("rst", '0, 1'b0, '0);

    // Basic average, back-to-back then with 8 idle cycles between strobes.
    for (int i = 0; i < 4; i++) send(32'(100 + 2 * i), 32'd1, 32'd0);
    idle(3);
    check_out("avg_b2b", 32'd103, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      send(32'(100 + 2 * i), 32'd1, 32'd0);
      idle(8);
    end
    check_out("avg_gap", 32'd103, 1'b0, '0);

    // Wrap across +/- full scale, then negative rounding.
    send(32'h7FFF_FFF0, 32'd1, 32'd0); send(32'h8000_0010, 32'd1, 32'd0);
    send(32'h7FFF_FFF0, 32'd1, 32'd0); send(32'h8000_0010, 32'd1, 32'd0);
    idle(2);
    check_out("wrap", 32'h8000_0000, 1'b0, '0);
    send(32'd10, 32'd1, 32'd0);
    for (int i = 0; i < 3; i++) send(32'd9, 32'd1, 32'd0);
    idle(2);
    check_out("neg_rnd", 32'd9, 1'b0, '0);

    // Magnitude gate, equality accepts.
    send(32'd50, 32'd999,  32'd1000); send(32'd50, 32'd1000, 32'd1000);
    send(32'd50, 32'd5000, 32'd1000); send(32'd50, 32'd0,    32'd1000);
    send(32'd50, 32'd2000, 32'd1000); send(32'd50, 32'd3000, 32'd1000);
    idle(2);
    check_out("gate", 32'd50, 1'b0, CNT_W'(2));

    // Timeout, then a clean block.
    for (int i = 0; i < MAXF; i++) send(32'd77, 32'd10, 32'd1000);
    idle(2);
    check_out("tmo", '0, 1'b1, CNT_W'(8));
    for (int i = 0; i < 4; i++) send(32'd7, 32'd2000, 32'd1000);
    idle(2);
    check_out("post_tmo", 32'd7, 1'b0, '0);

    // clr discards partial blocks, including with a coincident strobe.
    send(32'd500, 32'd1, 32'd0); send(32'd500, 32'd1, 32'd0);
    do_clr(1'b0);
    send(32'd500, 32'd1, 32'd0); send(32'd500, 32'd1, 32'd0);
    do_clr(1'b1);
    for (int i = 0; i < 4; i++) send(32'd20, 32'd1, 32'd0);
    idle(2);
    check_out("clr", 32'd20, 1'b0, '0);

    // Reset mid-block.
    for (int i = 0; i < 3; i++) send(32'd1000, 32'd1, 32'd0);
    @(negedge clk);
    rst = 1'b1; i_vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    check("mid_rst_vld", 64'(o_vld), 64'd0);
    check_out("mid_rst", '0, 1'b0, '0);
    for (int i = 0; i < 4; i++) send(32'hFFFF_FFF8, 32'd1, 32'd0);
    idle(2);
    check_out("post_rst", 32'hFFFF_FFF8, 1'b0, '0);

    // Randomized frames, gaps and clears.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        do_clr(1'($urandom_range(0, 1)));
      end else begin
        logic [MAG_W-1:0] t;
        logic [MAG_W-1:0] m;
        t = $urandom_range(0, 1000);
        m = ($urandom_range(0, 7) == 0) ? t : $urandom_range(0, 1400);
        send($urandom, m, t);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(4);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
